// File: rtl/parking_access_ctrl.sv
// Parking lot access controller: entry/exit barrier FSMs with gate timeouts,
// pending-event counters feeding a round-robin inc/dec arbiter for the
// external occupancy counter, lot-full indication and a combined alarm pulse.
module parking_access_ctrl #(
   parameter int unsigned CAPACITY   = 99,
   parameter int unsigned GATE_TICKS = 50_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       entry_req,
   input  logic       exit_req,
   input  logic       car_enter,
   input  logic       car_exit,
   input  logic [6:0] count,
   output logic       inc,
   output logic       dec,
   output logic       entry_open,
   output logic       exit_open,
   output logic       full,
   output logic       alarm
);

   localparam int unsigned     TW         = $clog2(GATE_TICKS);
   localparam logic [TW-1:0]   TIMER_LOAD = TW'(GATE_TICKS - 1);
   localparam logic [7:0]      CAP8       = 8'(CAPACITY);

   typedef enum logic {
      GATE_IDLE = 1'b0,
      GATE_OPEN = 1'b1
   } gate_state_t;

   gate_state_t   r_entry_state, r_exit_state;
   logic [TW-1:0] r_entry_timer, r_exit_timer;
   logic [1:0]    r_pend_inc, r_pend_dec;
   logic          r_rr;
   logic          r_inc, r_dec, r_alarm;

   gate_state_t   w_entry_state_nxt, w_exit_state_nxt;
   logic [TW-1:0] w_entry_timer_nxt, w_exit_timer_nxt;
   logic          w_entry_timeout, w_exit_timeout;
   logic [1:0]    w_pend_inc_nxt, w_pend_dec_nxt;
   logic          w_drop_inc, w_drop_dec;
   logic          w_grant_inc, w_grant_dec, w_rr_nxt;
   logic          w_alarm_nxt;
   logic [7:0]    w_occupancy;
   logic          w_full;
   logic          w_exit_allowed;
   logic          w_tailgate_in, w_tailgate_out;

   // Occupancy projection: counted cars, cars not yet counted, and a car
   // that may be rolling through an open entry gate right now.
   assign w_occupancy = {1'b0, count} + {6'b0, r_pend_inc}
                      + {7'b0, (r_entry_state == GATE_OPEN)};
   assign w_full      = (w_occupancy >= CAP8);

   // Exit only opens if the lot could contain a car at all.
   assign w_exit_allowed = (count != 7'd0) || (r_pend_inc != 2'd0);

   // A car passing a barrier that was never opened for it.
   assign w_tailgate_in  = car_enter && (r_entry_state == GATE_IDLE);
   assign w_tailgate_out = car_exit  && (r_exit_state  == GATE_IDLE);

   // Pending counters: an event seen while the counter already holds 3 is
   // dropped outright (even if a strobe drains one this cycle) and alarmed.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      w_drop_inc     = car_enter && (r_pend_inc == 2'd3);
      w_drop_dec     = car_exit  && (r_pend_dec == 2'd3);
      w_pend_inc_nxt = r_pend_inc + {1'b0, car_enter && !w_drop_inc} - {1'b0, r_inc};
      w_pend_dec_nxt = r_pend_dec + {1'b0, car_exit  && !w_drop_dec} - {1'b0, r_dec};
   end

   // Arbiter: grants are chosen from next-cycle pending values so an event
   // on an idle counter produces its strobe exactly one cycle later.
   always_comb begin
      w_grant_inc = 1'b0;
      w_grant_dec = 1'b0;
      w_rr_nxt    = r_rr;
      if ((w_pend_inc_nxt != 2'd0) && (w_pend_dec_nxt != 2'd0)) begin
         w_grant_inc = !r_rr;
         w_grant_dec = r_rr;
         w_rr_nxt    = !r_rr;
      end else begin
         w_grant_inc = (w_pend_inc_nxt != 2'd0);
         w_grant_dec = (w_pend_dec_nxt != 2'd0);
      end
   end

   // Gate FSMs: next state and timer for the entry and exit barriers.
   always_comb begin
      w_entry_state_nxt = r_entry_state;
      w_entry_timer_nxt = r_entry_timer;
      w_entry_timeout   = 1'b0;
      w_exit_state_nxt  = r_exit_state;
      w_exit_timer_nxt  = r_exit_timer;
      w_exit_timeout    = 1'b0;

      case (r_entry_state)
         GATE_IDLE: begin
            if (entry_req && !w_full) begin
               w_entry_state_nxt = GATE_OPEN;
               w_entry_timer_nxt = TIMER_LOAD;
            end
         end
         GATE_OPEN: begin
            if (car_enter) begin
               w_entry_state_nxt = GATE_IDLE;
               w_entry_timer_nxt = '0;
            end else if (r_entry_timer == '0) begin
               w_entry_state_nxt = GATE_IDLE;
               w_entry_timeout   = 1'b1;
            end else begin
               w_entry_timer_nxt = r_entry_timer - 1'b1;
            end
         end
         default: w_entry_state_nxt = GATE_IDLE;
      endcase

      case (r_exit_state)
         GATE_IDLE: begin
            if (exit_req && w_exit_allowed) begin
               w_exit_state_nxt = GATE_OPEN;
               w_exit_timer_nxt = TIMER_LOAD;
            end
         end
         GATE_OPEN: begin
            if (car_exit) begin
               w_exit_state_nxt = GATE_IDLE;
               w_exit_timer_nxt = '0;
            end else if (r_exit_timer == '0) begin
               w_exit_state_nxt = GATE_IDLE;
               w_exit_timeout   = 1'b1;
            end else begin
               w_exit_timer_nxt = r_exit_timer - 1'b1;
            end
         end
         default: w_exit_state_nxt = GATE_IDLE;
      endcase
   end

   // All alarm causes in a cycle merge into one registered pulse.
   assign w_alarm_nxt = w_drop_inc || w_drop_dec || w_tailgate_in || w_tailgate_out
                     || w_entry_timeout || w_exit_timeout;

   // State register: reset closes both gates and discards pending events.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values regardless of statement order.
      if (reset) begin
         r_entry_state <= GATE_IDLE;
         r_exit_state  <= GATE_IDLE;
         r_entry_timer <= '0;
         r_exit_timer  <= '0;
         r_pend_inc    <= 2'd0;
         r_pend_dec    <= 2'd0;
         r_rr          <= 1'b0;
         r_inc         <= 1'b0;
         r_dec         <= 1'b0;
         r_alarm       <= 1'b0;
      end else begin
         r_entry_state <= w_entry_state_nxt;
         r_exit_state  <= w_exit_state_nxt;
         r_entry_timer <= w_entry_timer_nxt;
         r_exit_timer  <= w_exit_timer_nxt;
         r_pend_inc    <= w_pend_inc_nxt;
         r_pend_dec    <= w_pend_dec_nxt;
         r_rr          <= w_rr_nxt;
         r_inc         <= w_grant_inc;
         r_dec         <= w_grant_dec;
         r_alarm       <= w_alarm_nxt;
      end
   end

   assign inc        = r_inc;
   assign dec        = r_dec;
   assign entry_open = (r_entry_state == GATE_OPEN);
   assign exit_open  = (r_exit_state  == GATE_OPEN);
   assign full       = w_full;
   assign alarm      = r_alarm;

endmodule
